// File: rtl/bldc_hall_drive.sv
`timescale 1ns/1ps
// bldc_hall_drive: six-step BLDC gate drive for one motor.
// Filters the Hall inputs, counts signed Hall steps, flags invalid codes and
// bad jumps, and drives three half-bridges from a signed PWM command with
// per-bridge dead-time protection.
module bldc_hall_drive #(
    parameter int DEADTIME    = 4,
    parameter int HALL_FILTER = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_tick,
    input  logic       set_pwm,
    input  logic [7:0] pwm_data,
    input  logic [2:0] hall,
    output logic [5:0] drive,
    output logic [7:0] hall_count,
    output logic       fault
);

    localparam int RUN_W = $clog2(HALL_FILTER + 1);
    localparam int DT_W  = $clog2(DEADTIME + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HALL_FILTER);
    localparam logic [DT_W-1:0]  DT_FULL = DT_W'(DEADTIME);

    // Forward rotation successor of a valid Hall code.
    function automatic logic [2:0] fwd_next(input logic [2:0] code);
        case (code)
            3'b101:  fwd_next = 3'b100;
            3'b100:  fwd_next = 3'b110;
            3'b110:  fwd_next = 3'b010;
            3'b010:  fwd_next = 3'b011;
            3'b011:  fwd_next = 3'b001;
            3'b001:  fwd_next = 3'b101;
            default: fwd_next = code;
        endcase
    endfunction

    function automatic logic code_valid(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    // Hall path state
    logic [2:0]       hall_meta, hall_sync, hall_last, hall_filt, hall_prev;
    logic [RUN_W-1:0] run_q, run_d;
    logic             hall_ok, prev_ok, accept, accept_q;
    logic             both_valid, step_fwd, step_rev, jump, hall_bad;

    // PWM / command state
    logic [6:0] pwm_cnt;
    logic [7:0] pending, active;
    logic       pwm_on, drive_on;

    // Commutation and bridge state; index 2 = phase A, 1 = B, 0 = C
    logic [2:0]            hi_fwd, lo_fwd, hi_mask, lo_mask;
    logic [2:0][1:0]       target, br_d, br_q;
    logic [2:0][DT_W-1:0]  dt_d, dt_rem;

    // Stability filter: length of the current run of identical synchronized codes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        run_d = RUN_W'(1);
        if (hall_sync == hall_last)
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
        accept = (run_d == RUN_MAX) && (hall_sync != hall_filt);
    end

    // Synchronize the raw Hall inputs and latch accepted codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_meta <= '0;
            hall_sync <= '0;
            hall_last <= '0;
            run_q     <= '0;
            hall_filt <= '0;
            hall_prev <= '0;
            hall_ok   <= 1'b0;
            prev_ok   <= 1'b0;
            accept_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            hall_meta <= hall;
            hall_sync <= hall_meta;
            hall_last <= hall_sync;
            run_q     <= run_d;
            accept_q  <= accept;
            if (accept) begin
                hall_prev <= hall_filt;
                prev_ok   <= hall_ok;
                hall_filt <= hall_sync;
                hall_ok   <= 1'b1;
            end
        end
    end

    // Classify the most recent acceptance as forward, reverse or illegal jump.
    always_comb begin
        both_valid = accept_q && prev_ok && code_valid(hall_prev) && code_valid(hall_filt);
        step_fwd   = both_valid && (fwd_next(hall_prev) == hall_filt);
        step_rev   = both_valid && (fwd_next(hall_filt) == hall_prev);
        jump       = both_valid && !step_fwd && !step_rev;
        hall_bad   = hall_ok && !code_valid(hall_filt);
    end

    // Step counter and fault flag, updated the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_count <= '0;
            fault      <= 1'b0;
        end else begin
            fault <= hall_bad || jump;
            if (step_fwd)
                hall_count <= hall_count + 8'd1;
            else if (step_rev)
                hall_count <= hall_count - 8'd1;
        end
    end

    // PWM counter and double-buffered command; pending goes live at the 126->0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            pending <= '0;
            active  <= '0;
        end else begin
            if (set_pwm)
                pending <= pwm_data;
            if (pwm_tick) begin
                if (pwm_cnt == 7'd126) begin
                    pwm_cnt <= '0;
                    active  <= set_pwm ? pwm_data : pending;
                end else begin
                    pwm_cnt <= pwm_cnt + 7'd1;
                end
            end
        end
    end

    // Forward commutation table: one-hot high-side and low-side phase per Hall code.
    always_comb begin
        hi_fwd = '0;
        lo_fwd = '0;
        case (hall_filt)
            3'b101:  begin hi_fwd = 3'b100; lo_fwd = 3'b010; end
            3'b100:  begin hi_fwd = 3'b100; lo_fwd = 3'b001; end
            3'b110:  begin hi_fwd = 3'b010; lo_fwd = 3'b001; end
            3'b010:  begin hi_fwd = 3'b010; lo_fwd = 3'b100; end
            3'b011:  begin hi_fwd = 3'b001; lo_fwd = 3'b100; end
            3'b001:  begin hi_fwd = 3'b001; lo_fwd = 3'b010; end
            default: begin hi_fwd = '0;     lo_fwd = '0;     end
        endcase
        // Reverse swaps which phase is chopped high and which is held low.
        hi_mask  = active[7] ? lo_fwd : hi_fwd;
        lo_mask  = active[7] ? hi_fwd : lo_fwd;
        pwm_on   = pwm_cnt < active[6:0];
        drive_on = hall_ok && !hall_bad && (active[6:0] != 7'd0);
    end

    // Per-bridge target and dead-time gate: off is immediate, on waits out the off time.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            target[p] = 2'b00;
            if (drive_on && hi_mask[p])
                target[p] = {pwm_on, 1'b0};
            else if (drive_on && lo_mask[p])
                target[p] = 2'b01;

            br_d[p] = 2'b00;
            if (target[p] != 2'b00) begin
                if (br_q[p] == target[p])
                    br_d[p] = target[p];
                else if ((br_q[p] == 2'b00) && (dt_rem[p] == '0))
                    br_d[p] = target[p];
            end

            dt_d[p] = dt_rem[p];
            if (br_d[p] != 2'b00)
                dt_d[p] = DT_FULL;
            else if (dt_rem[p] != '0)
                dt_d[p] = dt_rem[p] - DT_W'(1);
        end
    end

    // Bridge output registers; dead-time counters start full so reset counts as on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q   <= '0;
            dt_rem <= {3{DT_FULL}};
        end else begin
            br_q   <= br_d;
            dt_rem <= dt_d;
        end
    end

    assign drive = br_q;

endmodule

// File: tb/tb_bldc_hall_drive.sv
`timescale 1ns/1ps
// tb_bldc_hall_drive: directed self-checking bench for bldc_hall_drive.
module tb_bldc_hall_drive;

    localparam int DEADTIME    = 4;
    localparam int HALL_FILTER = 3;
    localparam int SETTLE      = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwm_tick;
    logic       set_pwm;
    logic [7:0] pwm_data;
    logic [2:0] hall;
    logic [5:0] drive;
    logic [7:0] hall_count;
    logic       fault;

    int checks = 0;
    int errors = 0;
    int pwm_model = 0;
    logic [7:0] exp_count = 8'd0;

    bldc_hall_drive #(
        .DEADTIME    (DEADTIME),
        .HALL_FILTER (HALL_FILTER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_tick   (pwm_tick),
        .set_pwm    (set_pwm),
        .pwm_data   (pwm_data),
        .hall       (hall),
        .drive      (drive),
        .hall_count (hall_count),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        pwm_tick = 1'b1;
        @(negedge clk);
        pwm_tick = 1'b0;
        pwm_model = (pwm_model == 126) ? 0 : pwm_model + 1;
        cycles(7);
    endtask

    task automatic run_to_wrap();
        do tick(); while (pwm_model != 0);
    endtask

    task automatic strobe(input logic [7:0] v);
        set_pwm  = 1'b1;
        pwm_data = v;
        @(negedge clk);
        set_pwm  = 1'b0;
    endtask

    task automatic step_hall(input string tag, input logic [2:0] code, input int delta,
                             input logic [5:0] exp_drive);
        hall = code;
        cycles(SETTLE);
        exp_count = exp_count + 8'(delta);
        check({tag, "_count"}, 32'(hall_count), 32'(exp_count));
        check({tag, "_drive"}, 32'(drive), 32'(exp_drive));
    endtask

    // Shoot-through and dead-time watchdog on every half-bridge.
    int         off_run [3];
    logic [1:0] prev_br [3];
    always @(negedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (!rst_n) begin
                off_run[p] = 0;
                prev_br[p] = 2'b00;
            end else begin
                check("no_shoot_through", 32'(drive[2*p +: 2] == 2'b11), 32'd0);
                if (prev_br[p] == 2'b00 && drive[2*p +: 2] != 2'b00)
                    check("deadtime_before_on", 32'(off_run[p] >= DEADTIME), 32'd1);
                off_run[p] = (drive[2*p +: 2] == 2'b00) ? off_run[p] + 1 : 0;
                prev_br[p] = drive[2*p +: 2];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int ah;
        logic bl_ok, other_ok;
        int n;
        int pulses;
        logic [2:0] fwd_codes [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        logic [5:0] fwd_drv   [6] = '{6'b100001, 6'b001001, 6'b011000,
                                      6'b010010, 6'b000110, 6'b100100};
        logic [2:0] rev_codes [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
        logic [5:0] rev_drv   [6] = '{6'b000110, 6'b010010, 6'b011000,
                                      6'b001001, 6'b100001, 6'b100100};

        rst_n = 1'b0; pwm_tick = 1'b0; set_pwm = 1'b0; pwm_data = 8'h00; hall = 3'b101;
        cycles(3);
        check("reset_drive", 32'(drive), 32'd0);
        check("reset_count", 32'(hall_count), 32'd0);
        check("reset_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;
        cycles(SETTLE);
        check("idle_drive_duty0", 32'(drive), 32'd0);
        check("first_accept_no_count", 32'(hall_count), 32'd0);

        // Duty 64: command only goes live at the wrap.
        strobe(8'h40);
        repeat (10) tick();
        check("pre_wrap_drive", 32'(drive), 32'd0);
        run_to_wrap();
        ah = 0; bl_ok = 1'b1; other_ok = 1'b1;
        for (int i = 0; i < 127; i++) begin
            if (i > 0) tick();
            if (drive[5]) ah++;
            if (!drive[2]) bl_ok = 1'b0;
            if (drive[4] | drive[3] | drive[1] | drive[0]) other_ok = 1'b0;
            if (i == 60) strobe(8'h7F);
        end
        check("duty64_high_ticks", 32'(ah), 32'd64);
        check("b_low_constant", 32'(bl_ok), 32'd1);
        check("other_fets_off", 32'(other_ok), 32'd0 + 32'd1);
        run_to_wrap();
        cycles(4);
        check("full_duty_101", 32'(drive), 32'(6'b100100));

        // Forward round trip then reverse round trip.
        for (int i = 0; i < 6; i++) step_hall("fwd_step", fwd_codes[i], 1, fwd_drv[i]);
        check("fwd_total", 32'(hall_count), 32'd6);
        for (int i = 0; i < 6; i++) step_hall("rev_step", rev_codes[i], -1, rev_drv[i]);
        check("rev_total", 32'(hall_count), 32'd0);
        step_hall("rev_wrap", 3'b001, -1, 6'b000110);
        check("count_0_minus_1", 32'(hall_count), 32'hFF);
        step_hall("back_101", 3'b101, 1, 6'b100100);

        // Glitch shorter than the filter.
        hall = 3'b100;
        cycles(HALL_FILTER - 1);
        hall = 3'b101;
        cycles(SETTLE);
        check("glitch_count", 32'(hall_count), 32'(exp_count));
        check("glitch_drive", 32'(drive), 32'(6'b100100));

        // Invalid code 111.
        hall = 3'b111;
        n = 0;
        while (!fault && n < SETTLE) begin @(negedge clk); n++; end
        check("invalid_fault", 32'(fault), 32'd1);
        check("invalid_drive_off", 32'(drive), 32'd0);
        cycles(10);
        check("invalid_fault_held", 32'(fault), 32'd1);
        check("invalid_count", 32'(hall_count), 32'(exp_count));
        hall = 3'b101;
        cycles(SETTLE);
        check("recover_fault", 32'(fault), 32'd0);
        check("recover_count", 32'(hall_count), 32'(exp_count));
        check("recover_drive", 32'(drive), 32'(6'b100100));

        // Non-adjacent jump 101 -> 110.
        hall = 3'b110;
        pulses = 0;
        repeat (SETTLE) begin @(negedge clk); if (fault) pulses++; end
        check("jump_pulse_cycles", 32'(pulses), 32'd1);
        check("jump_count", 32'(hall_count), 32'(exp_count));
        check("jump_drive", 32'(drive), 32'(6'b001001));
        step_hall("rev_110_100", 3'b100, -1, 6'b100001);
        step_hall("rev_100_101", 3'b101, -1, 6'b100100);

        // Direction change, with a later strobe coinciding with the wrap tick.
        run_to_wrap();
        strobe(8'h00);
        repeat (3) tick();
        check("set_pwm_no_early_effect", 32'(drive), 32'(6'b100100));
        while (pwm_model != 126) tick();
        pwm_tick = 1'b1; set_pwm = 1'b1; pwm_data = 8'hFF;
        @(negedge clk);
        pwm_tick = 1'b0; set_pwm = 1'b0;
        pwm_model = 0;
        check("dir_wrap_edge", 32'(drive), 32'(6'b100100));
        for (int i = 0; i < DEADTIME; i++) begin
            @(negedge clk);
            check("dir_deadtime_gap", 32'(drive), 32'd0);
        end
        @(negedge clk);
        check("dir_reverse_on", 32'(drive), 32'(6'b011000));
        cycles(5);
        check("pre_reset_count", 32'(hall_count), 32'(exp_count));

        // Asynchronous reset mid-conduction.
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_drive", 32'(drive), 32'd0);
        check("async_reset_count", 32'(hall_count), 32'd0);
        check("async_reset_fault", 32'(fault), 32'd0);
        cycles(2);
        rst_n = 1'b1;
        pwm_model = 0;
        exp_count = 8'd0;
        cycles(SETTLE);
        check("post_reset_drive", 32'(drive), 32'd0);
        check("post_reset_count", 32'(hall_count), 32'd0);
        run_to_wrap();
        cycles(4);
        check("post_reset_cmd_cleared", 32'(drive), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
